// File: rtl/piso_shift_transmitter.sv
// piso_shift_transmitter: valid/ready-loaded word shifted out serially, one bit per DIV clocks
// Ports:
//   clock, reset            rising-edge clock, asynchronous active-high reset
//   data_in, load_valid     word offered by the requester
//   load_ready              high in IDLE; a word is taken when load_valid && load_ready
//   serial_out              registered serial data, IDLE_LEVEL when not shifting
//   bit_strobe              pulse in the first cycle of each bit
//   busy                    high while shifting
//   done                    pulse in the first IDLE cycle after the last bit
module piso_shift_transmitter #(
    parameter int WIDTH      = 8,
    parameter int DIV        = 4,
    parameter int MSB_FIRST  = 1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             serial_out,
    output logic             bit_strobe,
    output logic             busy,
    output logic             done
);
    localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
    localparam int BW = WIDTH > 1 ? $clog2(WIDTH) : 1;
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t state, next_state;
    logic [WIDTH-1:0] shreg, shreg_nxt, shifted;
    logic [WIDTH:0] wide;
    logic [DW-1:0] div_cnt, div_nxt;
    logic [BW-1:0] bit_cnt, bit_nxt;
    logic accept, bit_end, last;
    logic serial_nxt, strobe_nxt, busy_nxt, done_nxt;
    function automatic logic head(input logic [WIDTH-1:0] x);
        return MSB_FIRST != 0 ? x[WIDTH-1] : x[0];
    endfunction
    assign load_ready = state == IDLE;
    assign accept     = load_valid && load_ready;
    assign bit_end    = state == SHIFT && div_cnt == DW'(DIV - 1);
    assign last       = bit_end && bit_cnt == BW'(WIDTH - 1);
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            shreg      <= '0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            serial_out <= IDLE_LEVEL;
            bit_strobe <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= next_state;
            shreg      <= shreg_nxt;
            div_cnt    <= div_nxt;
            bit_cnt    <= bit_nxt;
            serial_out <= serial_nxt;
            bit_strobe <= strobe_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
        end
    end
    always_comb begin
        next_state = state;
        if (state == IDLE && accept) next_state = SHIFT;
        if (last) next_state = IDLE;
    end
    always_comb begin
        // one extra bit so the fill works for WIDTH = 1 as well
        wide       = MSB_FIRST != 0 ? {shreg, IDLE_LEVEL} : {IDLE_LEVEL, shreg};
        shifted    = MSB_FIRST != 0 ? wide[WIDTH-1:0] : wide[WIDTH:1];
        shreg_nxt  = accept ? data_in : (bit_end && !last) ? shifted : shreg;
        div_nxt    = accept ? '0 : bit_end ? '0 : state == SHIFT ? div_cnt + DW'(1) : div_cnt;
        bit_nxt    = accept ? '0 : (bit_end && !last) ? bit_cnt + BW'(1) : bit_cnt;
        serial_nxt = accept ? head(data_in) : last ? IDLE_LEVEL : bit_end ? head(shifted)
                   : state == IDLE ? IDLE_LEVEL : serial_out;
        strobe_nxt = accept || (bit_end && !last);
        busy_nxt   = next_state == SHIFT;
        done_nxt   = last;
    end
endmodule
